// File: rtl/aes_pkg.sv
// aes_pkg: key-length encodings, Nk/Nr helpers, GF(2^8) helpers and FSM state type
package aes_pkg;
  typedef enum logic [1:0] {
    KL_128  = 2'd0,
    KL_192  = 2'd1,
    KL_256  = 2'd2,
    KL_RSVD = 2'd3
  } key_len_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EXPAND,
    S_FINISH
  } state_e;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NR_128 = 4'd10;

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    return NK_128 + {1'b0, kl, 1'b0};
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    return NR_128 + {1'b0, kl, 1'b0};
  endfunction

  function automatic logic [9:0] key_bits(input logic [1:0] kl);
    return 10'd128 + {2'b0, kl, 6'b0};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0), then the FIPS-197 affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
endpackage

// File: rtl/aes_key_schedule_seq_if.sv
// aes_key_schedule_seq_if: request/status/read-port bundle of the key expander
interface aes_key_schedule_seq_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy;
  logic         done;
  logic         err;
  logic         rk_valid;
  logic [3:0]   cur_nr;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  modport master (
    output start, key_len, key_in, rk_idx,
    input  busy, done, err, rk_valid, cur_nr, rk_out
  );

  modport slave (
    input  start, key_len, key_in, rk_idx,
    output busy, done, err, rk_valid, cur_nr, rk_out
  );
endinterface

// File: rtl/aes_subword.sv
// aes_subword: 32-bit combinational SubWord, one S-box per byte
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);
  for (genvar b = 0; b < 4; b++) begin : g_sb
    assign o_word[8*b +: 8] = sbox(i_word[8*b +: 8]);
  end
endmodule

// File: rtl/aes_key_schedule_seq.sv
// aes_key_schedule_seq: iterative AES-128/192/256 key expander, one schedule word per clock
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS       = 256,
  parameter bit RESET_CLEARS_STORE = 1'b1
) (
  input logic                    clk,
  input logic                    rst_n,
  aes_key_schedule_seq_if.slave  bus
);
  localparam int         MAX_NR   = MAX_KEY_BITS / 32 + 6;
  localparam int         DEPTH    = 4 * (MAX_NR + 1);
  localparam logic [9:0] MAX_BITS = 10'(MAX_KEY_BITS);

  state_e       r_state, w_state_nxt;
  logic [255:0] r_key;
  logic [3:0]   r_nk, r_nr;
  logic [5:0]   r_i;
  logic [2:0]   r_ph;
  logic [7:0]   r_rcon;
  logic         r_rk_valid, r_err;
  logic [31:0]  r_store [DEPTH];

  logic             w_legal, w_accept, w_last;
  logic [31:0]      w_prev, w_back, w_sub_in, w_sub, w_new;
  logic [5:0]       w_base;
  logic [DEPTH-1:0] w_we;
  logic [31:0]      w_wd [DEPTH];

  assign w_legal  = bus.key_len != KL_RSVD && key_bits(bus.key_len) <= MAX_BITS;
  assign w_accept = r_state == S_IDLE && bus.start && w_legal;
  assign w_last   = r_i == {r_nr, 2'b11};

  always_comb begin
    w_state_nxt = r_state == S_IDLE   ? (w_accept ? S_LOAD : S_IDLE) :
                  r_state == S_LOAD   ? S_EXPAND :
                  r_state == S_EXPAND ? (w_last ? S_FINISH : S_EXPAND) : S_IDLE;
  end

  // r_ph is i mod Nk, kept as a wrapping counter so no divider is needed
  assign w_prev   = r_store[r_i - 6'd1];
  assign w_back   = r_store[r_i - {2'b0, r_nk}];
  assign w_sub_in = r_ph == 3'd0 ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign w_new    = w_back ^ (r_ph == 3'd0 ? w_sub ^ {r_rcon, 24'h0} :
                              (r_nk == 4'd8 && r_ph == 3'd4) ? w_sub : w_prev);

  aes_subword u_subword (
    .i_word (w_sub_in),
    .o_word (w_sub)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_key      <= '0;
      r_nk       <= '0;
      r_nr       <= '0;
      r_i        <= '0;
      r_ph       <= '0;
      r_rcon     <= 8'h01;
      r_rk_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= r_state == S_IDLE && bus.start && !w_legal;
      if (w_accept) begin
        r_key      <= bus.key_in;
        r_nk       <= nk_of(bus.key_len);
        r_nr       <= nr_of(bus.key_len);
        r_rk_valid <= 1'b0;
      end
      if (r_state == S_LOAD) begin
        r_i    <= {2'b0, r_nk};
        r_ph   <= 3'd0;
        r_rcon <= 8'h01;
      end
      if (r_state == S_EXPAND) begin
        r_i  <= r_i + 6'd1;
        r_ph <= r_ph == r_nk[2:0] - 3'd1 ? 3'd0 : r_ph + 3'd1;
        if (r_ph == 3'd0) r_rcon <= xtime(r_rcon);
        if (w_last) r_rk_valid <= 1'b1;
      end
    end
  end

  // LOAD writes all Nk key words at once; EXPAND writes the single word w[i]
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_we[k] = (r_state == S_LOAD && k < int'(r_nk)) || (r_state == S_EXPAND && r_i == 6'(k));
      w_wd[k] = r_state == S_LOAD ? r_key[255-32*(k%8) -: 32] : w_new;
    end
  end

  if (RESET_CLEARS_STORE) begin : g_store_rst
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < DEPTH; k++) r_store[k] <= '0;
      end else begin
        for (int k = 0; k < DEPTH; k++) if (w_we[k]) r_store[k] <= w_wd[k];
      end
    end
  end else begin : g_store_nrst
    always_ff @(posedge clk) begin
      for (int k = 0; k < DEPTH; k++) if (w_we[k]) r_store[k] <= w_wd[k];
    end
  end

  assign w_base       = {bus.rk_idx, 2'b00};
  assign bus.rk_out   = bus.rk_idx > r_nr ? 128'h0 :
                        {r_store[w_base], r_store[w_base + 6'd1], r_store[w_base + 6'd2], r_store[w_base + 6'd3]};
  assign bus.busy     = r_state == S_LOAD || r_state == S_EXPAND;
  assign bus.done     = r_state == S_FINISH;
  assign bus.err      = r_err;
  assign bus.rk_valid = r_rk_valid;
  assign bus.cur_nr   = r_nr;
endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// tb_aes_key_schedule_seq: directed + random checks of the key expander against a FIPS-197 model
module tb_aes_key_schedule_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_acc = 0;
  logic [7:0] sb [256];
  logic [31:0] mw [60];
  int m_nr = 0;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_schedule_seq_if ifa ();
  aes_key_schedule_seq_if ifb ();

  aes_key_schedule_seq #(.MAX_KEY_BITS(256), .RESET_CLEARS_STORE(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  aes_key_schedule_seq #(.MAX_KEY_BITS(128), .RESET_CLEARS_STORE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int k = 0; k < 8; k++) if (b[k]) p = p ^ (16'(a) << k);
    for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h11b << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, c, s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sb[x] = s;
    end
  endtask

  task automatic model(input logic [255:0] key, input int kl);
    int nk;
    logic [7:0] rc;
    logic [31:0] t;
    nk = 4 + 2 * kl;
    m_nr = 10 + 2 * kl;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) mw[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (m_nr + 1); i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] exp_rk(input int j);
    if (j > m_nr) return 128'h0;
    return {mw[4*j], mw[4*j+1], mw[4*j+2], mw[4*j+3]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input logic [1:0] kl, input logic [255:0] key);
    ifa.start = 1'b1;
    ifa.key_len = kl;
    ifa.key_in = key;
    step();
    ifa.start = 1'b0;
    ifa.key_in = ~key;
    ifa.key_len = 2'd3;
    t_acc = cyc;
  endtask

  task automatic wait_done(input string tag, input int lat);
    int g;
    g = 0;
    while (ifa.done !== 1'b1 && g < 100) begin
      step();
      g++;
    end
    chk({tag, "_done"}, 128'(ifa.done), 128'd1);
    chk({tag, "_lat"}, 128'(cyc - t_acc + 1), 128'(lat));
  endtask

  task automatic rd(input int j);
    ifa.rk_idx = 4'(j);
    #2;
  endtask

  task automatic chk_all(input string tag);
    for (int j = 0; j < 16; j++) begin
      rd(j);
      chk($sformatf("%s_rk%0d", tag, j), ifa.rk_out, exp_rk(j));
    end
    step();
  endtask

  initial begin
    logic [255:0] key;
    logic [1:0] kl;
    logic seen;
    ifa.start = 1'b0; ifa.key_len = 2'd0; ifa.key_in = '0; ifa.rk_idx = 4'd0;
    ifb.start = 1'b0; ifb.key_len = 2'd0; ifb.key_in = '0; ifb.rk_idx = 4'd0;
    build_sbox();
    repeat (3) step();
    chk("rst_busy", 128'(ifa.busy), 128'd0);
    chk("rst_done", 128'(ifa.done), 128'd0);
    chk("rst_err", 128'(ifa.err), 128'd0);
    chk("rst_rkv", 128'(ifa.rk_valid), 128'd0);
    chk("rst_nr", 128'(ifa.cur_nr), 128'd0);
    chk("rst_rk0", ifa.rk_out, 128'h0);
    chk("rst_b_nr", 128'(ifb.cur_nr), 128'd0);
    rst_n = 1'b1;
    step();

    model(K128, 0);
    go(2'd0, K128);
    chk("a128_busy_load", 128'(ifa.busy), 128'd1);
    chk("a128_rkv_low", 128'(ifa.rk_valid), 128'd0);
    wait_done("a128", 42);
    chk("a128_rkv", 128'(ifa.rk_valid), 128'd1);
    chk("a128_busy_fin", 128'(ifa.busy), 128'd0);
    chk("a128_nr", 128'(ifa.cur_nr), 128'd10);
    ifa.start = 1'b1; ifa.key_len = 2'd1; ifa.key_in = K192;
    step();
    ifa.start = 1'b0;
    chk("fin_start_busy", 128'(ifa.busy), 128'd0);
    chk("fin_start_err", 128'(ifa.err), 128'd0);
    chk("done_pulse", 128'(ifa.done), 128'd0);
    chk("fin_start_nr", 128'(ifa.cur_nr), 128'd10);
    rd(1);  chk("a128_w4", 128'(ifa.rk_out[127:96]), 128'h a0fafe17);
    rd(10); chk("a128_rk10", ifa.rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk_all("a128");

    model(K192, 1);
    go(2'd1, K192);
    wait_done("a192", 48);
    chk("a192_nr", 128'(ifa.cur_nr), 128'd12);
    rd(1);  chk("a192_w6", 128'(ifa.rk_out[63:32]), 128'hfe0c91f7);
    rd(12); chk("a192_w51", 128'(ifa.rk_out[31:0]), 128'h01002202);
    rd(13); chk("a192_rk13", ifa.rk_out, 128'h0);
    chk_all("a192");

    model(K256, 2);
    go(2'd2, K256);
    wait_done("a256", 54);
    chk("a256_nr", 128'(ifa.cur_nr), 128'd14);
    rd(2);  chk("a256_w8", 128'(ifa.rk_out[127:96]), 128'h9ba35411);
    rd(3);  chk("a256_w12", 128'(ifa.rk_out[127:96]), 128'ha8b09c1a);
    rd(14); chk("a256_w59", 128'(ifa.rk_out[31:0]), 128'h706c631e);
    chk_all("a256");

    ifa.start = 1'b1; ifa.key_len = 2'd3; ifa.key_in = K128;
    step();
    ifa.start = 1'b0;
    chk("rsvd_err", 128'(ifa.err), 128'd1);
    chk("rsvd_busy", 128'(ifa.busy), 128'd0);
    chk("rsvd_rkv", 128'(ifa.rk_valid), 128'd1);
    chk("rsvd_nr", 128'(ifa.cur_nr), 128'd14);
    rd(14); chk("rsvd_rk14", ifa.rk_out, exp_rk(14));
    step();
    chk("rsvd_err_pulse", 128'(ifa.err), 128'd0);

    ifb.start = 1'b1; ifb.key_len = 2'd2; ifb.key_in = K256;
    step();
    ifb.start = 1'b0;
    chk("b_big_err", 128'(ifb.err), 128'd1);
    chk("b_big_busy", 128'(ifb.busy), 128'd0);
    ifb.start = 1'b1; ifb.key_len = 2'd0; ifb.key_in = K128;
    step();
    ifb.start = 1'b0; ifb.key_in = '0;
    repeat (41) step();
    chk("b128_done", 128'(ifb.done), 128'd1);
    chk("b128_nr", 128'(ifb.cur_nr), 128'd10);
    ifb.rk_idx = 4'd10; #2;
    chk("b128_rk10", ifb.rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    step();

    for (int r = 0; r < 4; r++) begin
      kl = 2'($urandom_range(0, 2));
      key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      model(key, int'(kl));
      go(kl, key);
      repeat ($urandom_range(2, 20)) step();
      ifa.start = 1'b1; ifa.key_len = 2'd0; ifa.key_in = ~key;
      step();
      ifa.start = 1'b0;
      chk($sformatf("rnd%0d_ign_busy", r), 128'(ifa.busy), 128'd1);
      chk($sformatf("rnd%0d_ign_err", r), 128'(ifa.err), 128'd0);
      wait_done($sformatf("rnd%0d", r), 2 + 4 * (m_nr + 1) - (4 + 2 * int'(kl)));
      chk($sformatf("rnd%0d_nr", r), 128'(ifa.cur_nr), 128'(m_nr));
      chk_all($sformatf("rnd%0d", r));
    end

    key = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
    go(2'd0, key);
    repeat (17) step();
    chk("mid_busy", 128'(ifa.busy), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(ifa.busy), 128'd0);
    chk("mid_rst_rkv", 128'(ifa.rk_valid), 128'd0);
    chk("mid_rst_nr", 128'(ifa.cur_nr), 128'd0);
    chk("mid_rst_done", 128'(ifa.done), 128'd0);
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (50) begin
      step();
      if (ifa.done) seen = 1'b1;
    end
    chk("mid_rst_no_done", 128'(seen), 128'd0);
    key = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
    model(key, 0);
    go(2'd0, key);
    wait_done("post_rst", 42);
    chk_all("post_rst");

    key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    model(key, 2);
    go(2'd2, key);
    wait_done("b2b256", 54);
    step();
    chk("b2b_rkv_before", 128'(ifa.rk_valid), 128'd1);
    key = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
    model(key, 0);
    go(2'd0, key);
    chk("b2b_rkv_accept", 128'(ifa.rk_valid), 128'd0);
    wait_done("b2b128", 42);
    chk("b2b_rkv_done", 128'(ifa.rk_valid), 128'd1);
    rd(12); chk("b2b_rk12", ifa.rk_out, 128'h0);
    chk_all("b2b128");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
